mem_arbiter: RTL and testbench

- Sequences the shared multi-cycle data RAM and arbitrates between two requesters:
  - the load-buffer port (reads);
  - the store-buffer port (writes).
- Holds address and data stable for the whole access, which the RAM requires.
- Waits for the RAM's readStatus/writeStatus pulse, then returns tagged completions to the reservation-station side.
- Sits between the load/store buffers and the RAM; one access is outstanding at a time.

---
 rtl/mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Front end for the shared multi-cycle data RAM. Arbitrates between the
//   load buffer (reads) and the store buffer (writes). Only one RAM access is
//   in flight at a time. Address, write data and the active strobe are held
//   stable for the whole access. When the RAM raises its status pulse, a
//   tagged one-cycle completion goes back to the requester side. A wait that
//   sees no status pulse is aborted after TIMEOUT cycles and reported with
//   err=1.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ld_req_*                 load request (valid/ready handshake, addr, tag)
//   st_req_*                 store request (valid/ready handshake, addr, data, tag)
//   ld_resp_*                load completion pulse (tag, data, err)
//   st_resp_*                store completion pulse (tag, err)
//   mem_addr, mem_wdata      registered RAM address / write data
//   mem_nRD, mem_nWR         registered active-low RAM strobes
//   mem_rdata                RAM read data
//   mem_readStatus           RAM read-done pulse
//   mem_writeStatus          RAM write-done pulse
//   busy                     high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int TAG_W   = 4,
  parameter int MEM_LAT = 10,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_req_valid,
  output logic             ld_req_ready,
  input  logic [31:0]      ld_req_addr,
  input  logic [TAG_W-1:0] ld_req_tag,
  input  logic             st_req_valid,
  output logic             st_req_ready,
  input  logic [31:0]      st_req_addr,
  input  logic [31:0]      st_req_data,
  input  logic [TAG_W-1:0] st_req_tag,
  output logic             ld_resp_valid,
  output logic [TAG_W-1:0] ld_resp_tag,
  output logic [31:0]      ld_resp_data,
  output logic             ld_resp_err,
  output logic             st_resp_valid,
  output logic [TAG_W-1:0] st_resp_tag,
  output logic             st_resp_err,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_nRD,
  output logic             mem_nWR,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_readStatus,
  input  logic             mem_writeStatus,
  output logic             busy
);

  localparam int DCNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int TCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // Drain runs for counter values 0..MEM_LAT, i.e. MEM_LAT+1 cycles.
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(MEM_LAT);
  localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);
  // The wait counter starts at 0 on the accept edge, so the abort edge is the
  // one where it holds TIMEOUT-1: exactly TIMEOUT wait cycles have elapsed.
  localparam logic [TCNT_W-1:0] TMO_LAST   = TCNT_W'(TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE   = TCNT_W'(1);

  typedef enum logic [2:0] {
    S_DRAIN   = 3'd0,
    S_IDLE    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_WAIT = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  // Registered state
  state_t             r_state;
  logic [DCNT_W-1:0]  r_dcnt;
  logic [TCNT_W-1:0]  r_tcnt;
  logic               r_last_st;      // 1: last grant went to the store port
  logic [TAG_W-1:0]   r_tag;          // tag of the access in flight
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_mem_nrd;
  logic               r_mem_nwr;
  logic               r_ld_resp_valid;
  logic [TAG_W-1:0]   r_ld_resp_tag;
  logic [31:0]        r_ld_resp_data;
  logic               r_ld_resp_err;
  logic               r_st_resp_valid;
  logic [TAG_W-1:0]   r_st_resp_tag;
  logic               r_st_resp_err;

  // Next-state values
  state_t             w_state_nxt;
  logic [DCNT_W-1:0]  w_dcnt_nxt;
  logic [TCNT_W-1:0]  w_tcnt_nxt;
  logic               w_last_st_nxt;
  logic [TAG_W-1:0]   w_tag_nxt;
  logic [31:0]        w_mem_addr_nxt;
  logic [31:0]        w_mem_wdata_nxt;
  logic               w_mem_nrd_nxt;
  logic               w_mem_nwr_nxt;
  logic               w_ld_resp_valid_nxt;
  logic [TAG_W-1:0]   w_ld_resp_tag_nxt;
  logic [31:0]        w_ld_resp_data_nxt;
  logic               w_ld_resp_err_nxt;
  logic               w_st_resp_valid_nxt;
  logic [TAG_W-1:0]   w_st_resp_tag_nxt;
  logic               w_st_resp_err_nxt;

  logic               w_idle;
  logic               w_grant_ld;
  logic               w_grant_st;
  logic               w_tmo;

  assign w_idle = (r_state == S_IDLE);

  // Round-robin: with both ports requesting, the port that did not win last
  // time is granted. The two grants are mutually exclusive by construction.
  assign w_grant_ld = w_idle && ld_req_valid && (!st_req_valid ||  r_last_st);
  assign w_grant_st = w_idle && st_req_valid && (!ld_req_valid || !r_last_st);

  assign w_tmo = (r_tcnt == TMO_LAST);

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt         = r_state;
    w_dcnt_nxt          = r_dcnt;
    w_tcnt_nxt          = r_tcnt;
    w_last_st_nxt       = r_last_st;
    w_tag_nxt           = r_tag;
    w_mem_addr_nxt      = r_mem_addr;
    w_mem_wdata_nxt     = r_mem_wdata;
    w_mem_nrd_nxt       = r_mem_nrd;
    w_mem_nwr_nxt       = r_mem_nwr;
    w_ld_resp_valid_nxt = 1'b0;
    w_ld_resp_tag_nxt   = r_ld_resp_tag;
    w_ld_resp_data_nxt  = r_ld_resp_data;
    w_ld_resp_err_nxt   = r_ld_resp_err;
    w_st_resp_valid_nxt = 1'b0;
    w_st_resp_tag_nxt   = r_st_resp_tag;
    w_st_resp_err_nxt   = r_st_resp_err;

    case (r_state)
      // The RAM's own latency counter survives our reset, so both strobes
      // are held inactive long enough for any access it was running to end.
      // Status pulses seen here belong to that stale access and are ignored.
      S_DRAIN: begin
        w_mem_nrd_nxt = 1'b1;
        w_mem_nwr_nxt = 1'b1;
        if (r_dcnt == DRAIN_LAST) begin
          w_dcnt_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_dcnt_nxt  = r_dcnt + DCNT_ONE;
        end
      end

      S_IDLE: begin
        if (w_grant_ld) begin
          w_mem_addr_nxt = ld_req_addr;
          w_tag_nxt      = ld_req_tag;
          w_last_st_nxt  = 1'b0;
          w_mem_nrd_nxt  = 1'b0;
          w_tcnt_nxt     = '0;
          w_state_nxt    = S_RD_WAIT;
        end else if (w_grant_st) begin
          w_mem_addr_nxt  = st_req_addr;
          w_mem_wdata_nxt = st_req_data;
          w_tag_nxt       = st_req_tag;
          w_last_st_nxt   = 1'b1;
          w_mem_nwr_nxt   = 1'b0;
          w_tcnt_nxt      = '0;
          w_state_nxt     = S_WR_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (mem_readStatus) begin
          w_ld_resp_valid_nxt = 1'b1;
          w_ld_resp_tag_nxt   = r_tag;
          w_ld_resp_data_nxt  = mem_rdata;
          w_ld_resp_err_nxt   = 1'b0;
          w_mem_nrd_nxt       = 1'b1;
          w_state_nxt         = S_RECOVER;
        end else if (w_tmo) begin
          w_ld_resp_valid_nxt = 1'b1;
          w_ld_resp_tag_nxt   = r_tag;
          w_ld_resp_data_nxt  = '0;
          w_ld_resp_err_nxt   = 1'b1;
          w_mem_nrd_nxt       = 1'b1;
          w_state_nxt         = S_RECOVER;
        end else begin
          w_tcnt_nxt          = r_tcnt + TCNT_ONE;
        end
      end

      S_WR_WAIT: begin
        if (mem_writeStatus) begin
          w_st_resp_valid_nxt = 1'b1;
          w_st_resp_tag_nxt   = r_tag;
          w_st_resp_err_nxt   = 1'b0;
          w_mem_nwr_nxt       = 1'b1;
          w_state_nxt         = S_RECOVER;
        end else if (w_tmo) begin
          w_st_resp_valid_nxt = 1'b1;
          w_st_resp_tag_nxt   = r_tag;
          w_st_resp_err_nxt   = 1'b1;
          w_mem_nwr_nxt       = 1'b1;
          w_state_nxt         = S_RECOVER;
        end else begin
          w_tcnt_nxt          = r_tcnt + TCNT_ONE;
        end
      end

      // One cycle with both strobes high lets the RAM counter return to 0
      // before the next access starts.
      S_RECOVER: begin
        w_mem_nrd_nxt = 1'b1;
        w_mem_nwr_nxt = 1'b1;
        w_state_nxt   = S_IDLE;
      end

      default: begin
        w_mem_nrd_nxt = 1'b1;
        w_mem_nwr_nxt = 1'b1;
        w_dcnt_nxt    = '0;
        w_state_nxt   = S_DRAIN;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_DRAIN;
      r_dcnt          <= '0;
      r_tcnt          <= '0;
      r_last_st       <= 1'b1;
      r_tag           <= '0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_nrd       <= 1'b1;
      r_mem_nwr       <= 1'b1;
      r_ld_resp_valid <= 1'b0;
      r_ld_resp_tag   <= '0;
      r_ld_resp_data  <= '0;
      r_ld_resp_err   <= 1'b0;
      r_st_resp_valid <= 1'b0;
      r_st_resp_tag   <= '0;
      r_st_resp_err   <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_dcnt          <= w_dcnt_nxt;
      r_tcnt          <= w_tcnt_nxt;
      r_last_st       <= w_last_st_nxt;
      r_tag           <= w_tag_nxt;
      r_mem_addr      <= w_mem_addr_nxt;
      r_mem_wdata     <= w_mem_wdata_nxt;
      r_mem_nrd       <= w_mem_nrd_nxt;
      r_mem_nwr       <= w_mem_nwr_nxt;
      r_ld_resp_valid <= w_ld_resp_valid_nxt;
      r_ld_resp_tag   <= w_ld_resp_tag_nxt;
      r_ld_resp_data  <= w_ld_resp_data_nxt;
      r_ld_resp_err   <= w_ld_resp_err_nxt;
      r_st_resp_valid <= w_st_resp_valid_nxt;
      r_st_resp_tag   <= w_st_resp_tag_nxt;
      r_st_resp_err   <= w_st_resp_err_nxt;
    end
  end

  assign ld_req_ready  = w_grant_ld;
  assign st_req_ready  = w_grant_st;
  assign ld_resp_valid = r_ld_resp_valid;
  assign ld_resp_tag   = r_ld_resp_tag;
  assign ld_resp_data  = r_ld_resp_data;
  assign ld_resp_err   = r_ld_resp_err;
  assign st_resp_valid = r_st_resp_valid;
  assign st_resp_tag   = r_st_resp_tag;
  assign st_resp_err   = r_st_resp_err;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_nRD       = r_mem_nrd;
  assign mem_nWR       = r_mem_nwr;
  assign busy          = !w_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A small nominal RAM model answers each
// access on the 10th edge after the strobe falls. It can be muted to force
// a timeout, and it can inject a stray readStatus pulse. Inputs are driven
// 1 time unit after a rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_req_valid;
  logic             ld_req_ready;
  logic [31:0]      ld_req_addr;
  logic [TAG_W-1:0] ld_req_tag;
  logic             st_req_valid;
  logic             st_req_ready;
  logic [31:0]      st_req_addr;
  logic [31:0]      st_req_data;
  logic [TAG_W-1:0] st_req_tag;
  logic             ld_resp_valid;
  logic [TAG_W-1:0] ld_resp_tag;
  logic [31:0]      ld_resp_data;
  logic             ld_resp_err;
  logic             st_resp_valid;
  logic [TAG_W-1:0] st_resp_tag;
  logic             st_resp_err;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_nRD;
  logic             mem_nWR;
  logic [31:0]      mem_rdata;
  logic             mem_readStatus;
  logic             mem_writeStatus;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  mem_arbiter #(.TAG_W(TAG_W), .MEM_LAT(10), .TIMEOUT(15)) dut (
    .clk             (clk),
    .rst             (rst),
    .ld_req_valid    (ld_req_valid),
    .ld_req_ready    (ld_req_ready),
    .ld_req_addr     (ld_req_addr),
    .ld_req_tag      (ld_req_tag),
    .st_req_valid    (st_req_valid),
    .st_req_ready    (st_req_ready),
    .st_req_addr     (st_req_addr),
    .st_req_data     (st_req_data),
    .st_req_tag      (st_req_tag),
    .ld_resp_valid   (ld_resp_valid),
    .ld_resp_tag     (ld_resp_tag),
    .ld_resp_data    (ld_resp_data),
    .ld_resp_err     (ld_resp_err),
    .st_resp_valid   (st_resp_valid),
    .st_resp_tag     (st_resp_tag),
    .st_resp_err     (st_resp_err),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_nRD         (mem_nRD),
    .mem_nWR         (mem_nWR),
    .mem_rdata       (mem_rdata),
    .mem_readStatus  (mem_readStatus),
    .mem_writeStatus (mem_writeStatus),
    .busy            (busy)
  );

  // Nominal RAM: counts cycles with a strobe low, raises status while the
  // count is 9 so that it is sampled on the 10th edge after the strobe fell.
  logic [7:0]  ram_cnt = 8'd0;
  logic        ram_en  = 1'b1;
  logic        spur_rd = 1'b0;
  logic [31:0] ram_mem [16] = '{default: 32'h0};

  always @(posedge clk) begin
    if (!mem_nRD || !mem_nWR) ram_cnt <= ram_cnt + 8'd1;
    else                      ram_cnt <= 8'd0;
    if (!mem_nWR && mem_writeStatus) ram_mem[mem_addr[5:2]] <= mem_wdata;
  end

  assign mem_readStatus  = (ram_en && !mem_nRD && ram_cnt == 8'd9) || spur_rd;
  assign mem_writeStatus =  ram_en && !mem_nWR && ram_cnt == 8'd9;
  assign mem_rdata       = ram_mem[mem_addr[5:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_val(input int sel);
    case (sel)
      0:       return ld_req_ready;
      1:       return st_req_ready;
      default: return !busy;
    endcase
  endfunction

  // Bounded wait (sampled on falling edges) for ld ready / st ready / idle.
  task automatic wait_sel(input int sel, input int max_cyc, input string tag);
    int   n;
    logic hit;
    n = 0;
    @(negedge clk);
    hit = sel_val(sel);
    while (!hit && n < max_cyc) begin
      @(negedge clk);
      n++;
      hit = sel_val(sel);
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  // Called 1 unit after the reset edge; walks the 11 drain cycles and ends on
  // the falling edge of the first IDLE cycle.
  task automatic drain_check(input bit spur);
    for (int i = 1; i <= 11; i++) begin
      if (spur) spur_rd = (i >= 3 && i <= 5);
      @(negedge clk);
      chk("drain_ld_ready", 32'(ld_req_ready), 32'd0);
      chk("drain_st_ready", 32'(st_req_ready), 32'd0);
      chk("drain_nrd",      32'(mem_nRD),      32'd1);
      chk("drain_nwr",      32'(mem_nWR),      32'd1);
      chk("drain_ld_resp",  32'(ld_resp_valid), 32'd0);
      chk("drain_st_resp",  32'(st_resp_valid), 32'd0);
      chk("drain_busy",     32'(busy),          32'd1);
      @(posedge clk);
      #1;
    end
    spur_rd = 1'b0;
    @(negedge clk);
    chk("drain_done_idle", 32'(busy), 32'd0);
  endtask

  // Called 1 unit after the accept edge; checks the 10 wait cycles and returns
  // on the edge where the status is sampled.
  task automatic wait_strobe(input bit is_ld, input logic [31:0] addr, input logic [31:0] wdata);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("wait_nrd",  32'(mem_nRD), is_ld ? 32'd0 : 32'd1);
      chk("wait_nwr",  32'(mem_nWR), is_ld ? 32'd1 : 32'd0);
      chk("wait_addr", mem_addr, addr);
      if (!is_ld) chk("wait_wdata", mem_wdata, wdata);
      chk("wait_no_resp", 32'(is_ld ? ld_resp_valid : st_resp_valid), 32'd0);
      @(posedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc [4];
    logic [31:0] ld6_data [4];
    ld6_data = '{32'h0, 32'h0, 32'h0000_1234, 32'h0};

    rst = 1'b1;
    ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_tag = '0;
    st_req_valid = 1'b0; st_req_addr = '0; st_req_data = '0; st_req_tag = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",      32'(busy),          32'd1);
    chk("rst_nrd",       32'(mem_nRD),       32'd1);
    chk("rst_nwr",       32'(mem_nWR),       32'd1);
    chk("rst_addr",      mem_addr,           32'd0);
    chk("rst_wdata",     mem_wdata,          32'd0);
    chk("rst_ld_valid",  32'(ld_resp_valid), 32'd0);
    chk("rst_ld_data",   ld_resp_data,       32'd0);
    chk("rst_ld_tag",    32'(ld_resp_tag),   32'd0);
    chk("rst_st_valid",  32'(st_resp_valid), 32'd0);
    chk("rst_st_err",    32'(st_resp_err),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- drain, then store 0x10 <= DEADBEEF tag 3 ----
    st_req_valid = 1'b1; st_req_addr = 32'h10; st_req_data = 32'hDEAD_BEEF; st_req_tag = 4'd3;
    drain_check(1'b0);
    chk("t1_st_ready_12th", 32'(st_req_ready), 32'd1);
    chk("t1_ld_ready_12th", 32'(ld_req_ready), 32'd0);
    @(posedge clk);
    #1;
    st_req_valid = 1'b0;
    wait_strobe(1'b0, 32'h10, 32'hDEAD_BEEF);
    #1;
    ld_req_valid = 1'b1; ld_req_addr = 32'h10; ld_req_tag = 4'd5;
    @(negedge clk);
    chk("t2_st_resp_valid", 32'(st_resp_valid), 32'd1);
    chk("t2_st_resp_tag",   32'(st_resp_tag),   32'd3);
    chk("t2_st_resp_err",   32'(st_resp_err),   32'd0);
    chk("t2_nwr_released",  32'(mem_nWR),       32'd1);
    chk("t2_recover_ready", 32'(ld_req_ready),  32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t2_st_resp_1cyc",  32'(st_resp_valid), 32'd0);
    chk("t2_ld_ready_idle", 32'(ld_req_ready),  32'd1);
    @(posedge clk);
    #1;
    ld_req_valid = 1'b0;
    wait_strobe(1'b1, 32'h10, 32'h0);
    @(negedge clk);
    chk("t2_ld_resp_valid", 32'(ld_resp_valid), 32'd1);
    chk("t2_ld_resp_tag",   32'(ld_resp_tag),   32'd5);
    chk("t2_ld_resp_data",  ld_resp_data,       32'hDEAD_BEEF);
    chk("t2_ld_resp_err",   32'(ld_resp_err),   32'd0);
    wait_sel(2, 20, "t2_idle_wait");

    // ---- round-robin after a fresh reset ----
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ld_req_valid = 1'b1; ld_req_addr = 32'h4; ld_req_tag = 4'd1;
    st_req_valid = 1'b1; st_req_addr = 32'h8; st_req_data = 32'h0000_1234; st_req_tag = 4'd2;
    drain_check(1'b0);
    chk("t3_ld_first",   32'(ld_req_ready), 32'd1);
    chk("t3_st_blocked", 32'(st_req_ready), 32'd0);
    @(posedge clk);
    #1;
    ld_req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t3_ld_resp_tag",  32'(ld_resp_valid ? ld_resp_tag : 4'hF), 32'd1);
    chk("t3_st_rdy_recov", 32'(st_req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t3_st_ready_a11", 32'(st_req_ready), 32'd1);
    @(posedge clk);
    #1;
    ld_req_valid = 1'b1; ld_req_addr = 32'hC; ld_req_tag = 4'd7;
    @(negedge clk);
    chk("t3_st_accepted_a12", 32'(mem_nWR), 32'd0);
    chk("t3_st_addr",         mem_addr,     32'h8);
    chk("t3_ld_ready_busy",   32'(ld_req_ready), 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t3_st_resp_valid", 32'(st_resp_valid), 32'd1);
    chk("t3_st_resp_tag",   32'(st_resp_tag),   32'd2);
    @(posedge clk);
    @(negedge clk);
    chk("t3_alt_ld_ready", 32'(ld_req_ready), 32'd1);
    chk("t3_alt_st_ready", 32'(st_req_ready), 32'd0);
    @(posedge clk);
    #1;
    ld_req_valid = 1'b0;
    st_req_valid = 1'b0;
    wait_sel(2, 20, "t3_idle_wait");

    // ---- timeout on a read ----
    ram_en = 1'b0;
    ld_req_valid = 1'b1; ld_req_addr = 32'h20; ld_req_tag = 4'd9;
    #1;
    chk("t4_ld_ready", 32'(ld_req_ready), 32'd1);
    @(posedge clk);
    #1;
    ld_req_valid = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("t4_no_resp_14", 32'(ld_resp_valid), 32'd0);
    chk("t4_nrd_low_14", 32'(mem_nRD),       32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_tmo_valid", 32'(ld_resp_valid), 32'd1);
    chk("t4_tmo_err",   32'(ld_resp_err),   32'd1);
    chk("t4_tmo_data",  ld_resp_data,       32'd0);
    chk("t4_tmo_tag",   32'(ld_resp_tag),   32'd9);
    chk("t4_tmo_nrd",   32'(mem_nRD),       32'd1);
    chk("t4_recover",   32'(busy),          32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("t4_resp_1cyc", 32'(ld_resp_valid), 32'd0);
    chk("t4_idle",      32'(busy),          32'd0);
    ram_en = 1'b1;
    st_req_valid = 1'b1; st_req_addr = 32'h24; st_req_data = 32'h55; st_req_tag = 4'd4;
    #1;
    chk("t4_post_st_ready", 32'(st_req_ready), 32'd1);
    @(posedge clk);
    #1;
    st_req_valid = 1'b0;
    @(negedge clk);
    chk("t4_post_nwr", 32'(mem_nWR), 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t4_post_st_valid", 32'(st_resp_valid), 32'd1);
    chk("t4_post_st_err",   32'(st_resp_err),   32'd0);
    chk("t4_post_st_tag",   32'(st_resp_tag),   32'd4);
    wait_sel(2, 20, "t4_idle_wait");

    // ---- reset in the 5th RD_WAIT cycle ----
    ld_req_valid = 1'b1; ld_req_addr = 32'h8; ld_req_tag = 4'd6;
    #1;
    chk("t5_ld_ready", 32'(ld_req_ready), 32'd1);
    @(posedge clk);
    #1;
    ld_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ld_req_valid = 1'b1; ld_req_addr = 32'h8; ld_req_tag = 4'd10;
    drain_check(1'b1);
    chk("t5_ready_after_drain", 32'(ld_req_ready), 32'd1);
    @(posedge clk);
    #1;
    ld_req_valid = 1'b0;
    wait_strobe(1'b1, 32'h8, 32'h0);
    @(negedge clk);
    chk("t5_ld_resp_valid", 32'(ld_resp_valid), 32'd1);
    chk("t5_ld_resp_tag",   32'(ld_resp_tag),   32'd10);
    chk("t5_ld_resp_data",  ld_resp_data,       32'h0000_1234);
    wait_sel(2, 20, "t5_idle_wait");

    // ---- back-to-back loads with valid held high ----
    ld_req_valid = 1'b1; ld_req_addr = 32'h0; ld_req_tag = 4'd11;
    for (int j = 0; j < 4; j++) begin
      wait_sel(0, 30, "t6_ready_wait");
      @(posedge clk);
      #1;
      acc[j] = cyc_cnt;
      if (j < 3) begin
        ld_req_addr = 32'(4 * (j + 1));
        ld_req_tag  = TAG_W'(12 + j);
      end else begin
        ld_req_valid = 1'b0;
      end
      if (j > 0) chk("t6_accept_gap", 32'(acc[j] - acc[j-1]), 32'd12);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("t6_resp_valid", 32'(ld_resp_valid), 32'd1);
      chk("t6_resp_tag",   32'(ld_resp_tag),   32'(11 + j));
      chk("t6_resp_data",  ld_resp_data,       ld6_data[j]);
    end
    wait_sel(2, 20, "t6_idle_wait");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
